// File: rtl/cpu_step_sequencer_if.sv
// Control/status bundle between the step sequencer and the CPU datapath.
// The master side is the sequencer; the slave side is the datapath or debug host.
interface cpu_step_sequencer_if #(
  parameter int PC_W = 8
);
  logic            run;
  logic            step;
  logic [15:0]     instr;
  logic            zero;
  logic [PC_W-1:0] pc;
  logic            imem_rd;
  logic [2:0]      ra1;
  logic [2:0]      ra2;
  logic [2:0]      wa3;
  logic            we3;
  logic [2:0]      alu_ctrl;
  logic            wd_imm_sel;
  logic [7:0]      imm;
  logic            halted;
  logic [2:0]      state;
  logic [15:0]     instr_count;

  modport master (
    input  run, step, instr, zero,
    output pc, imem_rd, ra1, ra2, wa3, we3, alu_ctrl, wd_imm_sel, imm,
           halted, state, instr_count
  );

  modport slave (
    output run, step, instr, zero,
    input  pc, imem_rd, ra1, ra2, wa3, we3, alu_ctrl, wd_imm_sel, imm,
           halted, state, instr_count
  );
endinterface

// File: rtl/cpu_step_sequencer.sv
// Multi-cycle fetch/decode/exec/write-back controller for the CPU v0.1 datapath,
// with free-run and single-step modes and a saturating retired-instruction count.
module cpu_step_sequencer #(
  parameter int         PC_W     = 8,
  parameter int         IMEM_LAT = 1,
  parameter logic [2:0] ALU_ADD  = 3'b000,
  parameter logic [2:0] ALU_SUB  = 3'b001
) (
  input logic                  clk,
  input logic                  rst_n,
  cpu_step_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] OP_ALU  = 3'b001;
  localparam logic [2:0] OP_LI   = 3'b010;
  localparam logic [2:0] OP_BEQ  = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam int         CNT_W   = (IMEM_LAT > 1) ? $clog2(IMEM_LAT) : 1;

  state_t          cur, nxt;
  logic [15:0]     ir;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, pc_br;
  logic [CNT_W-1:0] wait_cnt;
  logic [15:0]     cnt_q;
  logic            halted_q;
  logic [2:0]      op;
  logic            wait_done;
  logic            retire;

  assign op        = ir[15:13];
  assign wait_done = (wait_cnt == CNT_W'(IMEM_LAT - 1));
  assign pc_inc    = pc_q + PC_W'(1);
  assign pc_br     = pc_q + {{(PC_W-4){ir[3]}}, ir[3:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt    = cur;
    pc_d   = pc_q;
    retire = 1'b0;
    case (cur)
      S_IDLE:   if (bus.run || bus.step) nxt = S_FETCH;
      S_FETCH:  nxt = S_WAIT;
      S_WAIT:   if (wait_done) nxt = S_DECODE;
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_ALU, OP_LI: nxt = S_WB;
          OP_HALT:       nxt = S_HALT;
          OP_BEQ: begin
            pc_d   = bus.zero ? pc_br : pc_inc;
            retire = 1'b1;
          end
          OP_JMP: begin
            pc_d   = ir[PC_W-1:0];
            retire = 1'b1;
          end
          default: begin
            pc_d   = pc_inc;
            retire = 1'b1;
          end
        endcase
      end
      S_WB: begin
        pc_d   = pc_inc;
        retire = 1'b1;
      end
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_IDLE;
    endcase
    // A falling run lets the current instruction finish, then parks in IDLE.
    if (retire) nxt = bus.run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= '0;
      ir       <= '0;
      wait_cnt <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      if (cur == S_FETCH)
        wait_cnt <= '0;
      else if (cur == S_WAIT && !wait_done)
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (cur == S_WAIT && wait_done)
        ir <= bus.instr;
      if (retire && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
      if (cur == S_EXEC && op == OP_HALT)
        halted_q <= 1'b1;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.imem_rd     = (cur == S_FETCH);
  assign bus.we3         = (cur == S_WB);
  assign bus.ra1         = ir[9:7];
  assign bus.ra2         = ir[6:4];
  assign bus.wa3         = ir[12:10];
  assign bus.imm         = ir[7:0];
  assign bus.wd_imm_sel  = (op == OP_LI);
  assign bus.alu_ctrl    = (op == OP_ALU) ? ir[2:0] : (op == OP_BEQ) ? ALU_SUB : ALU_ADD;
  assign bus.halted      = halted_q;
  assign bus.state       = cur;
  assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed bench: two sequencers (IMEM_LAT 1 and 3) each driving a small
// instruction-memory and register-file/ULA model.
module tb_cpu_step_sequencer;
  logic clk = 1'b0;
  logic rst1, rst3;
  always #5 clk = ~clk;

  cpu_step_sequencer_if #(.PC_W(8)) b1 ();
  cpu_step_sequencer_if #(.PC_W(8)) b3 ();

  cpu_step_sequencer #(.PC_W(8), .IMEM_LAT(1)) u1 (.clk(clk), .rst_n(rst1), .bus(b1));
  cpu_step_sequencer #(.PC_W(8), .IMEM_LAT(3)) u3 (.clk(clk), .rst_n(rst3), .bus(b3));

  logic [15:0] mem [256];
  logic [7:0]  rf1 [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
  logic [7:0]  rf3 [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
  logic        rp1 = 1'b0;
  logic [2:0]  rp3 = 3'b000;
  logic [7:0]  a1 = 8'h00, a3 = 8'h00;

  function automatic logic [7:0] alu_f(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    case (c)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Read data is valid only in the cycle IMEM_LAT after the strobe; 16'hFFFF otherwise.
  always @(posedge clk) begin
    rp1 <= b1.imem_rd;
    rp3 <= {rp3[1:0], b3.imem_rd};
    if (b1.imem_rd) a1 <= b1.pc;
    if (b3.imem_rd) a3 <= b3.pc;
    if (b1.we3) rf1[b1.wa3] <= b1.wd_imm_sel ? b1.imm : alu_f(b1.alu_ctrl, rf1[b1.ra1], rf1[b1.ra2]);
    if (b3.we3) rf3[b3.wa3] <= b3.wd_imm_sel ? b3.imm : alu_f(b3.alu_ctrl, rf3[b3.ra1], rf3[b3.ra2]);
  end

  assign b1.instr = rp1    ? mem[a1] : 16'hFFFF;
  assign b3.instr = rp3[2] ? mem[a3] : 16'hFFFF;
  assign b1.zero  = (alu_f(b1.alu_ctrl, rf1[b1.ra1], rf1[b1.ra2]) == 8'h00);
  assign b3.zero  = (alu_f(b3.alu_ctrl, rf3[b3.ra1], rf3[b3.ra2]) == 8'h00);

  int we_cnt1 = 0, rd_cnt1 = 0, we_cnt3 = 0, both = 0;
  logic [2:0] wa_last1 = '0;
  logic [7:0] imm_last1 = '0;
  logic       sel_last1 = 1'b0;
  logic [7:0] fetch_q [$];

  always @(negedge clk) begin
    if (b1.we3) begin
      we_cnt1++;
      wa_last1  = b1.wa3;
      imm_last1 = b1.imm;
      sel_last1 = b1.wd_imm_sel;
    end
    if (b1.imem_rd) begin
      rd_cnt1++;
      fetch_q.push_back(b1.pc);
    end
    if (b3.we3) we_cnt3++;
    if ((b1.we3 && b1.imem_rd) || (b3.we3 && b3.imem_rd)) both++;
  end

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base_we, base_rd, qb, n;
    int exp_pc [10] = '{0, 1, 2, 4, 5, 6, 7, 16, 14, 255};

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst1 = 1'b0; rst3 = 1'b0;
    b1.run = 1'b0; b1.step = 1'b0; b3.run = 1'b0; b3.step = 1'b0;
    mem[0] = 16'h4405;                      // LI r1,5
    tick(3);

    chk("rst_state", b1.state, 0);
    chk("rst_pc", b1.pc, 0);
    chk("rst_ctl", {b1.we3, b1.imem_rd, b1.halted}, 0);
    chk("rst_count", b1.instr_count, 0);
    chk("rst_decode", {b1.ra1, b1.ra2, b1.wa3, b1.alu_ctrl, b1.imm, b1.wd_imm_sel}, 0);

    rst1 = 1'b1;
    base_we = we_cnt1; base_rd = rd_cnt1;
    tick(20);
    chk("idle_state", b1.state, 0);
    chk("idle_pc", b1.pc, 0);
    chk("idle_we3", we_cnt1 - base_we, 0);
    chk("idle_imem_rd", rd_cnt1 - base_rd, 0);

    // Single step of LI r1,5
    base_we = we_cnt1;
    b1.step = 1'b1; tick(1); b1.step = 1'b0;
    tick(8);
    chk("li_we_pulses", we_cnt1 - base_we, 1);
    chk("li_wa3", wa_last1, 1);
    chk("li_imm", imm_last1, 5);
    chk("li_sel", sel_last1, 1);
    chk("li_pc", b1.pc, 1);
    chk("li_count", b1.instr_count, 1);
    chk("li_state", b1.state, 0);
    chk("li_rf", rf1[1], 5);

    // Second step pulse while busy must not queue another instruction
    base_rd = rd_cnt1;
    b1.step = 1'b1; tick(1); b1.step = 1'b0;
    tick(1); b1.step = 1'b1; tick(1); b1.step = 1'b0;
    tick(8);
    chk("busy_step_fetches", rd_cnt1 - base_rd, 1);
    chk("busy_step_pc", b1.pc, 2);
    chk("busy_step_count", b1.instr_count, 2);

    // Free-run program covering BEQ taken/not taken, ALU, JMP and pc wrap
    rst1 = 1'b0; tick(2);
    mem[0]     = 16'h4403;                  // LI r1,3
    mem[1]     = 16'h4803;                  // LI r2,3
    mem[2]     = 16'h60A2;                  // BEQ r1,r2,+2
    mem[3]     = 16'hE000;                  // HALT (skipped)
    mem[4]     = 16'h4C04;                  // LI r3,4
    mem[5]     = 16'h60B2;                  // BEQ r1,r3,+2 (not taken)
    mem[6]     = 16'h3191;                  // r4 = r3 - r1
    mem[7]     = 16'h8010;                  // JMP 0x10
    mem[8'h10] = 16'h609E;                  // BEQ r1,r1,-2
    mem[8'h0E] = 16'h80FF;                  // JMP 0xFF
    mem[8'hFF] = 16'h0000;                  // NOP, wraps to 0
    rst1 = 1'b1;
    qb = fetch_q.size();
    b1.run = 1'b1;
    n = 0;
    while (fetch_q.size() < qb + 10 && n < 300) begin tick(1); n++; end
    b1.run = 1'b0;
    tick(6);
    chk("run_fetch_count", fetch_q.size() - qb, 10);
    for (int i = 0; i < 10; i++) chk("run_fetch_pc", fetch_q[qb + i], exp_pc[i]);
    chk("run_wrap_pc", b1.pc, 0);
    chk("run_stop_state", b1.state, 0);
    chk("run_count", b1.instr_count, 10);
    chk("run_rf3", rf1[3], 4);
    chk("run_rf4_alu", rf1[4], 1);

    // HALT at pc 3 is absorbing
    rst1 = 1'b0; tick(2);
    mem[2] = 16'h0000;
    rst1 = 1'b1;
    b1.run = 1'b1;
    n = 0;
    while (!b1.halted && n < 200) begin tick(1); n++; end
    chk("halt_reached", b1.halted, 1);
    chk("halt_state", b1.state, 6);
    chk("halt_pc", b1.pc, 3);
    b1.run = 1'b0; b1.step = 1'b1; tick(1); b1.step = 1'b0; b1.run = 1'b1;
    tick(5);
    b1.run = 1'b0; b1.step = 1'b1; tick(1); b1.step = 1'b0;
    tick(3);
    chk("halt_hold_state", b1.state, 6);
    chk("halt_hold_pc", b1.pc, 3);
    chk("halt_hold_flag", b1.halted, 1);
    rst1 = 1'b0; tick(1);
    chk("halt_rst_flag", b1.halted, 0);
    chk("halt_rst_state", b1.state, 0);

    // IMEM_LAT=3: ir capture timing, then reset during EXEC of an ALU op
    mem[0] = 16'h3191;                      // r4 = r3 - r1
    rst3 = 1'b1; tick(1);
    b3.step = 1'b1; tick(1); b3.step = 1'b0;
    chk("l3_fetch", b3.imem_rd, 1);
    tick(3);
    chk("l3_wait_state", b3.state, 2);
    chk("l3_no_early_ir", b3.wa3, 0);
    tick(1);
    chk("l3_decode_state", b3.state, 3);
    chk("l3_ir_fields", {b3.wa3, b3.ra1, b3.ra2, b3.alu_ctrl}, {3'd4, 3'd3, 3'd1, 3'd1});
    tick(1);
    chk("l3_exec_state", b3.state, 4);
    base_we = we_cnt3;
    rst3 = 1'b0; tick(1);
    chk("l3_rst_we3", b3.we3, 0);
    chk("l3_rst_pc", b3.pc, 0);
    chk("l3_rst_state", b3.state, 0);
    tick(3);
    chk("l3_rst_no_write", we_cnt3 - base_we, 0);
    chk("l3_rst_rf4", rf3[4], 4);

    // Full ALU op at IMEM_LAT=3: WB lands 6 cycles after FETCH
    rst3 = 1'b1;
    b3.step = 1'b1; tick(1); b3.step = 1'b0;
    tick(6);
    chk("l3_wb_state", b3.state, 5);
    chk("l3_wb_we3", {b3.we3, b3.wa3, b3.wd_imm_sel}, {1'b1, 3'd4, 1'b0});
    tick(1);
    chk("l3_done_state", b3.state, 0);
    chk("l3_done_pc", b3.pc, 1);
    chk("l3_done_count", b3.instr_count, 1);
    chk("l3_rf4_alu", rf3[4], 2);

    chk("rd_we_overlap", both, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
